// File: rtl/cp0_pkg.sv
// cp0_pkg: CP0 register indices, SR/Cause bit positions and exception codes.
package cp0_pkg;
   localparam logic [4:0] REG_COUNT   = 5'd9;
   localparam logic [4:0] REG_COMPARE = 5'd11;
   localparam logic [4:0] REG_SR      = 5'd12;
   localparam logic [4:0] REG_CAUSE   = 5'd13;
   localparam logic [4:0] REG_EPC     = 5'd14;
   localparam logic [4:0] REG_PRID    = 5'd15;
   localparam int SR_IE     = 0;
   localparam int SR_EXL    = 1;
   localparam int SR_IM_LO  = 10;
   localparam int CAUSE_EXC_LO = 2;
   localparam int CAUSE_IP_LO  = 10;
   localparam int CAUSE_TI     = 30;
   localparam int CAUSE_BD     = 31;
   localparam logic [4:0] EXC_INT     = 5'd0;
   localparam logic [4:0] EXC_ADEL    = 5'd4;
   localparam logic [4:0] EXC_ADES    = 5'd5;
   localparam logic [4:0] EXC_SYSCALL = 5'd8;
   localparam logic [4:0] EXC_RI      = 5'd10;
   localparam logic [4:0] EXC_OV      = 5'd12;
endpackage

// File: rtl/cp0_timer.sv
// cp0_timer: free-running Count, Compare and the latched timer-interrupt pending flag.
module cp0_timer (
   input  logic        clk,
   input  logic        reset,
   input  logic        wr_count,
   input  logic        wr_compare,
   input  logic [31:0] din,
   output logic [31:0] count,
   output logic [31:0] compare,
   output logic        pend
);
   always_ff @(posedge clk) begin
      if (reset) begin
         count   <= '0;
         compare <= '0;
         pend    <= 1'b0;
      end else begin
         count <= wr_count ? din : count + 32'd1;
         if (wr_compare) compare <= din;
         pend <= wr_compare ? 1'b0 : (pend | ((count == compare) && (compare != '0)));
      end
   end
endmodule

// File: rtl/cp0_unit.sv
// cp0_unit: MIPS coprocessor 0 (SR/Cause/EPC/PRId, interrupt/exception arbitration).
// Optional Count/Compare timer enabled by defining CP0_TIMER_EN.
module cp0_unit
   import cp0_pkg::*;
#(
   parameter logic [31:0] PRID_VALUE = 32'h0000_2024,
   parameter int          HWINT_W    = 6
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               En,
   input  logic [4:0]         CP0Add,
   input  logic [31:0]        CP0In,
   output logic [31:0]        CP0Out,
   input  logic [31:0]        VPC,
   input  logic               BDIn,
   input  logic [4:0]         ExcCodeIn,
   input  logic [HWINT_W-1:0] HWInt,
   input  logic               EXLClr,
   output logic [31:0]        EPCOut,
   output logic               Req
);
   logic [HWINT_W-1:0] im, ip, ip_next;
   logic               exl, ie, bd;
   logic [4:0]         exc_code;
   logic [31:0]        epc, sr, cause, count, compare;
   logic               pend, int_req, exc_req, wr;
   assign wr = En & ~Req;
`ifdef CP0_TIMER_EN
   cp0_timer u_timer (
      .clk        (clk),
      .reset      (reset),
      .wr_count   (wr && CP0Add == REG_COUNT),
      .wr_compare (wr && CP0Add == REG_COMPARE),
      .din        (CP0In),
      .count      (count),
      .compare    (compare),
      .pend       (pend)
   );
`else
   assign count   = '0;
   assign compare = '0;
   assign pend    = 1'b0;
`endif
   // The timer interrupt shares the topmost hardware interrupt line.
   assign ip_next = HWInt | {pend, {(HWINT_W-1){1'b0}}};
   assign int_req = ~exl & ie & |(im & ip_next);
   assign exc_req = ~exl & (ExcCodeIn != EXC_INT);
   assign Req     = int_req | exc_req;
   assign sr      = {16'b0, im, 8'b0, exl, ie};
   assign cause   = {bd, pend, 14'b0, ip, 3'b0, exc_code, 2'b0};
   assign EPCOut  = (En && CP0Add == REG_EPC) ? CP0In : epc;
   always_comb begin
      CP0Out = (CP0Add == REG_SR)      ? sr :
               (CP0Add == REG_CAUSE)   ? cause :
               (CP0Add == REG_EPC)     ? epc :
               (CP0Add == REG_PRID)    ? PRID_VALUE :
               (CP0Add == REG_COUNT)   ? count :
               (CP0Add == REG_COMPARE) ? compare : 32'b0;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         im       <= '0;
         ip       <= '0;
         exl      <= 1'b0;
         ie       <= 1'b0;
         bd       <= 1'b0;
         exc_code <= '0;
         epc      <= '0;
      end else begin
         ip <= ip_next;
         if (Req) begin
            exl      <= 1'b1;
            bd       <= BDIn;
            exc_code <= int_req ? EXC_INT : ExcCodeIn;
            epc      <= (BDIn ? VPC - 32'd4 : VPC) & 32'hFFFF_FFFC;
         end else begin
            if (EXLClr) exl <= 1'b0;
            if (wr && CP0Add == REG_SR) begin
               im  <= CP0In[SR_IM_LO +: HWINT_W];
               exl <= CP0In[SR_EXL];
               ie  <= CP0In[SR_IE];
            end
            if (wr && CP0Add == REG_EPC) epc <= CP0In;
         end
      end
   end
endmodule

// File: tb/tb_cp0_unit.sv
// tb_cp0_unit: directed-vector bench for cp0_unit; one vector per clock cycle.
module tb_cp0_unit;
   logic        clk = 1'b0, reset = 1'b1;
   logic        En = 1'b0, BDIn = 1'b0, EXLClr = 1'b0;
   logic [4:0]  CP0Add = '0, ExcCodeIn = '0;
   logic [31:0] CP0In = '0, VPC = '0;
   logic [5:0]  HWInt = '0;
   logic [31:0] CP0Out, EPCOut;
   logic        Req;
   int          nvec = 0, nerr = 0;

   typedef struct {
      logic        en;
      logic [4:0]  add;
      logic [31:0] din;
      logic [31:0] vpc;
      logic        bd;
      logic [4:0]  exc;
      logic [5:0]  hw;
      logic        clr;
      logic        req;
      logic [31:0] out;
      logic [31:0] epco;
   } vec_t;
   vec_t tbl[$];

   cp0_unit dut (
      .clk       (clk),
      .reset     (reset),
      .En        (En),
      .CP0Add    (CP0Add),
      .CP0In     (CP0In),
      .CP0Out    (CP0Out),
      .VPC       (VPC),
      .BDIn      (BDIn),
      .ExcCodeIn (ExcCodeIn),
      .HWInt     (HWInt),
      .EXLClr    (EXLClr),
      .EPCOut    (EPCOut),
      .Req       (Req)
   );

   always #5 clk = ~clk;

   task automatic drive(input logic en, input logic [4:0] add, input logic [31:0] din,
                        input logic [31:0] vpc, input logic bd, input logic [4:0] exc,
                        input logic [5:0] hw, input logic clr);
      En = en; CP0Add = add; CP0In = din; VPC = vpc;
      BDIn = bd; ExcCodeIn = exc; HWInt = hw; EXLClr = clr;
   endtask

   task automatic check(input string name, input logic req, input logic [31:0] out,
                        input logic [31:0] epco);
      nvec++;
      if (Req !== req || CP0Out !== out || EPCOut !== epco) begin
         nerr++;
         $display("FAIL %s: Req=%0b CP0Out=%h EPCOut=%h, want Req=%0b CP0Out=%h EPCOut=%h",
                  name, Req, CP0Out, EPCOut, req, out, epco);
      end
   endtask

   // Inputs change at negedge, outputs are checked 2ns later, state updates at the next posedge.
   task automatic step(input string name, input logic en, input logic [4:0] add,
                       input logic [31:0] din, input logic [5:0] hw, input logic clr,
                       input logic req, input logic [31:0] out, input logic [31:0] epco);
      drive(en, add, din, 32'h0, 1'b0, 5'd0, hw, clr);
      #2 check(name, req, out, epco);
      @(negedge clk);
   endtask

   initial begin
      //         en add  din           vpc           bd exc    hw     clr  req  out           epco
      tbl.push_back('{0, 12, 32'h0,         32'h0,        0, 5'd0,  6'h00, 0,   0, 32'h0,        32'h0});
      tbl.push_back('{0, 13, 32'h0,         32'h0,        0, 5'd0,  6'h00, 0,   0, 32'h0,        32'h0});
      tbl.push_back('{0, 14, 32'h0,         32'h0,        0, 5'd0,  6'h00, 0,   0, 32'h0,        32'h0});
      tbl.push_back('{0, 15, 32'h0,         32'h0,        0, 5'd0,  6'h00, 0,   0, 32'h0000_2024, 32'h0});
      tbl.push_back('{0, 3,  32'h0,         32'h0,        0, 5'd0,  6'h00, 0,   0, 32'h0,        32'h0});
      tbl.push_back('{1, 12, 32'hFFFF_7C01, 32'h0,        0, 5'd0,  6'h00, 0,   0, 32'h0,        32'h0});
      tbl.push_back('{0, 12, 32'h0,         32'h0,        0, 5'd0,  6'h00, 0,   0, 32'h0000_7C01, 32'h0});
      tbl.push_back('{0, 13, 32'h0,         32'h1000,     0, 5'd0,  6'h01, 0,   1, 32'h0,        32'h0});
      tbl.push_back('{0, 13, 32'h0,         32'h0,        0, 5'd0,  6'h01, 0,   0, 32'h0000_0400, 32'h1000});
      tbl.push_back('{0, 12, 32'h0,         32'h0,        0, 5'd0,  6'h00, 0,   0, 32'h0000_7C03, 32'h1000});
      tbl.push_back('{0, 14, 32'h0,         32'h0,        0, 5'd12, 6'h00, 0,   0, 32'h1000,     32'h1000});
      tbl.push_back('{0, 12, 32'h0,         32'h0,        0, 5'd0,  6'h00, 1,   0, 32'h0000_7C03, 32'h1000});
      tbl.push_back('{0, 12, 32'h0,         32'h0,        0, 5'd0,  6'h00, 0,   0, 32'h0000_7C01, 32'h1000});
      tbl.push_back('{0, 13, 32'h0,         32'h3010,     1, 5'd12, 6'h00, 0,   1, 32'h0,        32'h1000});
      tbl.push_back('{0, 13, 32'h0,         32'h0,        0, 5'd0,  6'h00, 0,   0, 32'h8000_0030, 32'h300C});
      tbl.push_back('{0, 14, 32'h0,         32'h0,        0, 5'd0,  6'h00, 0,   0, 32'h300C,     32'h300C});
      tbl.push_back('{0, 12, 32'h0,         32'h0,        0, 5'd0,  6'h00, 1,   0, 32'h0000_7C03, 32'h300C});
      tbl.push_back('{1, 12, 32'h0,         32'h2000,     0, 5'd8,  6'h00, 0,   1, 32'h0000_7C01, 32'h300C});
      tbl.push_back('{0, 12, 32'h0,         32'h0,        0, 5'd0,  6'h00, 0,   0, 32'h0000_7C03, 32'h2000});
      tbl.push_back('{0, 13, 32'h0,         32'h0,        0, 5'd0,  6'h00, 0,   0, 32'h0000_0020, 32'h2000});
      tbl.push_back('{0, 14, 32'h0,         32'h0,        0, 5'd0,  6'h00, 1,   0, 32'h2000,     32'h2000});
      tbl.push_back('{0, 12, 32'h0,         32'h2400,     0, 5'd10, 6'h00, 1,   1, 32'h0000_7C01, 32'h2000});
      tbl.push_back('{0, 12, 32'h0,         32'h0,        0, 5'd0,  6'h00, 0,   0, 32'h0000_7C03, 32'h2400});
      tbl.push_back('{1, 14, 32'h3100,      32'h0,        0, 5'd0,  6'h00, 0,   0, 32'h2400,     32'h3100});
      tbl.push_back('{0, 14, 32'h0,         32'h0,        0, 5'd0,  6'h00, 1,   0, 32'h3100,     32'h3100});
      tbl.push_back('{1, 14, 32'h5555_5557, 32'h0,        0, 5'd0,  6'h00, 0,   0, 32'h3100,     32'h5555_5557});
      tbl.push_back('{0, 14, 32'h0,         32'h0,        0, 5'd0,  6'h00, 0,   0, 32'h5555_5557, 32'h5555_5557});
      tbl.push_back('{0, 12, 32'h0,         32'h4004,     0, 5'd4,  6'h02, 0,   1, 32'h0000_7C01, 32'h5555_5557});
      tbl.push_back('{0, 13, 32'h0,         32'h0,        0, 5'd0,  6'h00, 0,   0, 32'h0000_0800, 32'h4004});
      tbl.push_back('{0, 12, 32'h0,         32'h0,        0, 5'd0,  6'h20, 1,   0, 32'h0000_7C03, 32'h4004});
      tbl.push_back('{0, 13, 32'h0,         32'h0,        0, 5'd0,  6'h20, 0,   0, 32'h0000_8000, 32'h4004});
      tbl.push_back('{1, 13, 32'hFFFF_FFFF, 32'h0,        0, 5'd0,  6'h00, 0,   0, 32'h0000_8000, 32'h4004});
      tbl.push_back('{0, 13, 32'h0,         32'h0,        0, 5'd0,  6'h00, 0,   0, 32'h0,        32'h4004});
      tbl.push_back('{0, 12, 32'h0,         32'h10,       0, 5'd5,  6'h00, 0,   1, 32'h0000_7C01, 32'h4004});
      tbl.push_back('{0, 14, 32'h0,         32'h0,        0, 5'd0,  6'h00, 0,   0, 32'h10,       32'h10});

      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < tbl.size(); i++) begin
         drive(tbl[i].en, tbl[i].add, tbl[i].din, tbl[i].vpc, tbl[i].bd, tbl[i].exc,
               tbl[i].hw, tbl[i].clr);
         #2 check($sformatf("vec%0d", i), tbl[i].req, tbl[i].out, tbl[i].epco);
         @(negedge clk);
      end

      // Reset while EXL=1: handler state cleared, interrupts disabled afterwards.
      drive(1'b0, 5'd12, 32'h0, 32'h0, 1'b0, 5'd0, 6'h00, 1'b0);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      step("rst_sr",      0, 12, 32'h0, 6'h01, 0, 0, 32'h0, 32'h0);
      step("rst_epc",     0, 14, 32'h0, 6'h01, 0, 0, 32'h0, 32'h0);
      step("rst_cause",   0, 13, 32'h0, 6'h00, 0, 0, 32'h0000_0400, 32'h0);

`ifdef CP0_TIMER_EN
      step("tm_wcount",   1, 9,  32'h0, 6'h00, 0, 0, CP0Out, 32'h0);
      step("tm_wcmp",     1, 11, 32'h5, 6'h00, 0, 0, 32'h0, 32'h0);
      step("tm_wsr",      1, 12, 32'h0000_8001, 6'h00, 0, 0, 32'h0, 32'h0);
      step("tm_cnt2",     0, 9,  32'h0, 6'h00, 0, 0, 32'h2, 32'h0);
      step("tm_cnt3",     0, 9,  32'h0, 6'h00, 0, 0, 32'h3, 32'h0);
      step("tm_cnt4",     0, 9,  32'h0, 6'h00, 0, 0, 32'h4, 32'h0);
      step("tm_cnt5",     0, 9,  32'h0, 6'h00, 0, 0, 32'h5, 32'h0);
      step("tm_req",      0, 13, 32'h0, 6'h00, 0, 1, 32'h4000_0000, 32'h0);
      step("tm_cause",    0, 13, 32'h0, 6'h00, 0, 0, 32'h4000_8000, 32'h0);
      step("tm_clrcmp",   1, 11, 32'h0, 6'h00, 0, 0, 32'h5, 32'h0);
      step("tm_eret",     0, 13, 32'h0, 6'h00, 1, 0, 32'h0000_8000, 32'h0);
      step("tm_quiet",    0, 13, 32'h0, 6'h00, 0, 0, 32'h0, 32'h0);
`else
      step("notm_w9",     1, 9,  32'h1234, 6'h00, 0, 0, 32'h0, 32'h0);
      step("notm_r9",     0, 9,  32'h0, 6'h00, 0, 0, 32'h0, 32'h0);
      step("notm_w11",    1, 11, 32'h1, 6'h00, 0, 0, 32'h0, 32'h0);
      step("notm_r11",    0, 11, 32'h0, 6'h00, 0, 0, 32'h0, 32'h0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
